// File: rtl/id_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_decode_stage_pkg
// Shared definitions for the instruction-decode stage of the 16-bit pipeline:
// data/register widths, opcode and ALU-operation encodings, the ID/EX
// pipeline-register record, and small helpers (imm6 sign extension, bubble).
// -----------------------------------------------------------------------------
package id_decode_stage_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;
    localparam int INSTR_W  = 16;

    // Opcodes, instruction bits [15:12]; 9..15 decode as NOP
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;

    // ALU operation codes seen by EX
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam logic [REG_AW-1:0] REG_ZERO  = 3'd0;
    localparam logic [DATA_W-1:0] DATA_ZERO = 16'h0000;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [2:0]        alu_op;
        logic              alu_src_imm;
        logic              mem_rd;
        logic              mem_wr;
        logic              reg_wr;
        logic              branch;
        logic              valid;
    } idex_t;

    // Sign-extend the 6-bit immediate field to the datapath width
    function automatic logic [DATA_W-1:0] sext_imm6(input logic [5:0] imm6);
        return {{(DATA_W-6){imm6[5]}}, imm6};
    endfunction

    // An all-zero ID/EX record: no valid instruction, no side effects
    function automatic idex_t idex_bubble();
        idex_t b;
        b = {$bits(idex_t){1'b0}};
        return b;
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// -----------------------------------------------------------------------------
// id_decode_stage_if
// Bundles the decode stage's pipeline-side signals.
//   master : upstream/downstream pipeline (drives IF/ID, flush, write-back;
//            observes the stall and the ID/EX register)
//   slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface id_decode_stage_if;
    import id_decode_stage_pkg::*;

    // IF/ID, flush and write-back inputs to the stage
    logic [INSTR_W-1:0] Instr_IF_ID;
    logic               Valid_IF_ID;
    logic               Flush_EX;
    logic               WbEn;
    logic [REG_AW-1:0]  WbAddr;
    logic [DATA_W-1:0]  WbData;

    // Stage outputs
    logic               Stall_IF;
    logic [REG_AW-1:0]  RegRd_ID_EX;
    logic [REG_AW-1:0]  RegRs1_ID_EX;
    logic [REG_AW-1:0]  RegRs2_ID_EX;
    logic [DATA_W-1:0]  Rs1Data_ID_EX;
    logic [DATA_W-1:0]  Rs2Data_ID_EX;
    logic [DATA_W-1:0]  Imm_ID_EX;
    logic [2:0]         AluOp_ID_EX;
    logic               AluSrcImm_ID_EX;
    logic               MemRd_ID_EX;
    logic               MemWr_ID_EX;
    logic               RegWr_ID_EX;
    logic               Branch_ID_EX;
    logic               Valid_ID_EX;

    modport master (
        output Instr_IF_ID, Valid_IF_ID, Flush_EX, WbEn, WbAddr, WbData,
        input  Stall_IF, RegRd_ID_EX, RegRs1_ID_EX, RegRs2_ID_EX,
               Rs1Data_ID_EX, Rs2Data_ID_EX, Imm_ID_EX, AluOp_ID_EX,
               AluSrcImm_ID_EX, MemRd_ID_EX, MemWr_ID_EX, RegWr_ID_EX,
               Branch_ID_EX, Valid_ID_EX
    );

    modport slave (
        input  Instr_IF_ID, Valid_IF_ID, Flush_EX, WbEn, WbAddr, WbData,
        output Stall_IF, RegRd_ID_EX, RegRs1_ID_EX, RegRs2_ID_EX,
               Rs1Data_ID_EX, Rs2Data_ID_EX, Imm_ID_EX, AluOp_ID_EX,
               AluSrcImm_ID_EX, MemRd_ID_EX, MemWr_ID_EX, RegWr_ID_EX,
               Branch_ID_EX, Valid_ID_EX
    );

endinterface

// File: rtl/reg_file_8x16.sv
// -----------------------------------------------------------------------------
// reg_file_8x16
// 8 x 16-bit flip-flop register file with two combinational read ports.
// R0 is hard-wired to zero. A write in the current cycle is forwarded to a
// matching read port (write-through bypass), so ID sees WB data immediately.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset (clears all)
//   wr_en/addr/data     : write-back port, committed on the rising edge
//   rd_addr_a/rd_data_a : read port A
//   rd_addr_b/rd_data_b : read port B
// -----------------------------------------------------------------------------
module reg_file_8x16
    import id_decode_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              wr_live_s;

    // Writes to R0 are discarded, both for storage and for the bypass
    assign wr_live_s = wr_en && (wr_addr != REG_ZERO);

    // Register storage, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= DATA_ZERO;
            end
        end else if (wr_live_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port A: R0 reads zero, same-cycle write wins over stored value
    always_comb begin
        if (rd_addr_a == REG_ZERO) begin
            rd_data_a = DATA_ZERO;
        end else if (wr_live_s && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        if (rd_addr_b == REG_ZERO) begin
            rd_data_b = DATA_ZERO;
        end else if (wr_live_s && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// -----------------------------------------------------------------------------
// id_decode_stage
// Instruction-decode stage: decodes the IF/ID instruction, reads operands from
// the register file, detects load-use hazards against the instruction in
// ID/EX, and owns the ID/EX pipeline register.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset (ID/EX bubble, register file zero)
//   bus   : id_decode_stage_if.slave -- IF/ID instruction, flush, write-back
//           in; Stall_IF (combinational) and ID/EX register fields out
// -----------------------------------------------------------------------------
module id_decode_stage
    import id_decode_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    id_decode_stage_if.slave bus
);

    logic [3:0]        opcode_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] rs1_s;
    logic [REG_AW-1:0] rs2_s;
    logic [5:0]        imm6_s;

    logic              use_rs1_s;
    logic              use_rs2_s;
    logic              uses_imm_s;
    logic [2:0]        alu_op_s;
    logic              alu_src_imm_s;
    logic              mem_rd_s;
    logic              mem_wr_s;
    logic              reg_wr_s;
    logic              branch_s;

    logic [REG_AW-1:0] rs1_addr_s;
    logic [REG_AW-1:0] rs2_addr_s;
    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;

    logic              hazard_match_s;
    logic              stall_s;
    idex_t             next_s;
    idex_t             idex_r;

    assign opcode_s = bus.Instr_IF_ID[15:12];
    assign rd_s     = bus.Instr_IF_ID[11:9];
    assign rs1_s    = bus.Instr_IF_ID[8:6];
    assign rs2_s    = bus.Instr_IF_ID[5:3];
    assign imm6_s   = bus.Instr_IF_ID[5:0];

    // Control decode; unknown opcodes fall through as NOP
    always_comb begin
        use_rs1_s     = 1'b0;
        use_rs2_s     = 1'b0;
        uses_imm_s    = 1'b0;
        alu_op_s      = ALU_ADD;
        alu_src_imm_s = 1'b0;
        mem_rd_s      = 1'b0;
        mem_wr_s      = 1'b0;
        reg_wr_s      = 1'b0;
        branch_s      = 1'b0;
        case (opcode_s)
            OP_NOP: begin
                reg_wr_s = 1'b0;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                use_rs1_s  = 1'b1;
                use_rs2_s  = 1'b1;
                uses_imm_s = 1'b1;
                reg_wr_s   = 1'b1;
                case (opcode_s)
                    OP_SUB:  alu_op_s = ALU_SUB;
                    OP_AND:  alu_op_s = ALU_AND;
                    OP_OR:   alu_op_s = ALU_OR;
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            OP_ADDI: begin
                use_rs1_s     = 1'b1;
                uses_imm_s    = 1'b1;
                alu_src_imm_s = 1'b1;
                reg_wr_s      = 1'b1;
            end
            OP_LD: begin
                use_rs1_s     = 1'b1;
                uses_imm_s    = 1'b1;
                alu_src_imm_s = 1'b1;
                mem_rd_s      = 1'b1;
                reg_wr_s      = 1'b1;
            end
            OP_ST: begin
                // Address is rs1+imm; rs2 supplies store data
                use_rs1_s     = 1'b1;
                use_rs2_s     = 1'b1;
                uses_imm_s    = 1'b1;
                alu_src_imm_s = 1'b1;
                mem_wr_s      = 1'b1;
            end
            OP_BEQ: begin
                // Compare by subtraction; imm carries the branch offset
                use_rs1_s  = 1'b1;
                use_rs2_s  = 1'b1;
                uses_imm_s = 1'b1;
                alu_op_s   = ALU_SUB;
                branch_s   = 1'b1;
            end
            default: begin
                reg_wr_s = 1'b0;
            end
        endcase
    end

    // Unused sources read (and are reported as) R0 so forwarding never matches
    assign rs1_addr_s = use_rs1_s ? rs1_s : REG_ZERO;
    assign rs2_addr_s = use_rs2_s ? rs2_s : REG_ZERO;

    reg_file_8x16 u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (bus.WbEn),
        .wr_addr   (bus.WbAddr),
        .wr_data   (bus.WbData),
        .rd_addr_a (rs1_addr_s),
        .rd_data_a (rs1_data_s),
        .rd_addr_b (rs2_addr_s),
        .rd_data_b (rs2_data_s)
    );

    // Load-use hazard: the load in ID/EX produces a register ID needs now.
    // A same-cycle write-back does not cancel it; a flush does.
    assign hazard_match_s = (use_rs1_s && (rs1_s == idex_r.rd)) ||
                            (use_rs2_s && (rs2_s == idex_r.rd));
    assign stall_s = bus.Valid_IF_ID && idex_r.valid && idex_r.mem_rd &&
                     (idex_r.rd != REG_ZERO) && hazard_match_s && !bus.Flush_EX;

    // Next ID/EX contents: bubble on flush, stall or empty IF/ID
    always_comb begin
        next_s = idex_bubble();
        if (bus.Flush_EX || stall_s || !bus.Valid_IF_ID) begin
            next_s = idex_bubble();
        end else begin
            next_s.rd          = reg_wr_s ? rd_s : REG_ZERO;
            next_s.rs1         = rs1_addr_s;
            next_s.rs2         = rs2_addr_s;
            next_s.rs1_data    = rs1_data_s;
            next_s.rs2_data    = rs2_data_s;
            next_s.imm         = uses_imm_s ? sext_imm6(imm6_s) : DATA_ZERO;
            next_s.alu_op      = alu_op_s;
            next_s.alu_src_imm = alu_src_imm_s;
            next_s.mem_rd      = mem_rd_s;
            next_s.mem_wr      = mem_wr_s;
            next_s.reg_wr      = reg_wr_s;
            next_s.branch      = branch_s;
            next_s.valid       = 1'b1;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_r <= idex_bubble();
        end else begin
            idex_r <= next_s;
        end
    end

    assign bus.Stall_IF        = stall_s;
    assign bus.RegRd_ID_EX     = idex_r.rd;
    assign bus.RegRs1_ID_EX    = idex_r.rs1;
    assign bus.RegRs2_ID_EX    = idex_r.rs2;
    assign bus.Rs1Data_ID_EX   = idex_r.rs1_data;
    assign bus.Rs2Data_ID_EX   = idex_r.rs2_data;
    assign bus.Imm_ID_EX       = idex_r.imm;
    assign bus.AluOp_ID_EX     = idex_r.alu_op;
    assign bus.AluSrcImm_ID_EX = idex_r.alu_src_imm;
    assign bus.MemRd_ID_EX     = idex_r.mem_rd;
    assign bus.MemWr_ID_EX     = idex_r.mem_wr;
    assign bus.RegWr_ID_EX     = idex_r.reg_wr;
    assign bus.Branch_ID_EX    = idex_r.branch;
    assign bus.Valid_ID_EX     = idex_r.valid;

endmodule

// File: tb/tb_id_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_id_decode_stage
// Directed scoreboard bench for id_decode_stage. The driver pushes the
// hand-computed ID/EX contents expected after each edge; a monitor pops and
// compares one entry after every rising edge. Stall_IF is checked right after
// inputs settle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_decode_stage;

    logic clk = 1'b0;
    logic reset;

    id_decode_stage_if bus();

    id_decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [65:0] exp_q[$];
    int          tag_q[$];
    logic [65:0] idex_s;

    assign idex_s = {bus.RegRd_ID_EX, bus.RegRs1_ID_EX, bus.RegRs2_ID_EX,
                     bus.Rs1Data_ID_EX, bus.Rs2Data_ID_EX, bus.Imm_ID_EX,
                     bus.AluOp_ID_EX, bus.AluSrcImm_ID_EX, bus.MemRd_ID_EX,
                     bus.MemWr_ID_EX, bus.RegWr_ID_EX, bus.Branch_ID_EX,
                     bus.Valid_ID_EX};

    localparam logic [65:0] BUB = 66'h0;
    // control bits: {alu_src_imm, mem_rd, mem_wr, reg_wr, branch, valid}
    localparam logic [5:0] C_R    = 6'b000101;
    localparam logic [5:0] C_ADDI = 6'b100101;
    localparam logic [5:0] C_LD   = 6'b110101;
    localparam logic [5:0] C_ST   = 6'b101001;
    localparam logic [5:0] C_BEQ  = 6'b000011;
    localparam logic [5:0] C_NOP  = 6'b000001;

    function automatic logic [65:0] mk(input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic [15:0] d1,
                                       input logic [15:0] d2, input logic [15:0] imm,
                                       input logic [2:0] aluop, input logic [5:0] ctl);
        return {rd, rs1, rs2, d1, d2, imm, aluop, ctl};
    endfunction

    task automatic check(input string nm, input int tag, input logic [65:0] got,
                         input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, tag, got, exp);
        end
    endtask

    // Monitor: one expected ID/EX record is due after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check("idex", tag_q.pop_front(), idex_s, exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, check stall, queue expectation
    task automatic step(input int tag, input logic [15:0] instr, input logic vld,
                        input logic flush, input logic wben, input logic [2:0] wa,
                        input logic [15:0] wd, input logic exp_stall,
                        input logic [65:0] exp);
        bus.Instr_IF_ID = instr;
        bus.Valid_IF_ID = vld;
        bus.Flush_EX    = flush;
        bus.WbEn        = wben;
        bus.WbAddr      = wa;
        bus.WbData      = wd;
        #1;
        check("stall", tag, {65'h0, bus.Stall_IF}, {65'h0, exp_stall});
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.Instr_IF_ID = 16'h0000;
        bus.Valid_IF_ID = 1'b0;
        bus.Flush_EX    = 1'b0;
        bus.WbEn        = 1'b0;
        bus.WbAddr      = 3'd0;
        bus.WbData      = 16'h0000;
        reset           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_idex", 0, idex_s, BUB);
        check("reset_stall", 0, {65'h0, bus.Stall_IF}, 66'h0);
        reset = 1'b0;

        // R3 = 1234, then ADD r1 = r3 + r0
        step(1,  16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, BUB);
        step(2,  16'h12C0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd1, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000, 3'd0, C_R));
        // SUB r6 = r2 - r3 with R2 = BEEF written this same cycle (bypass)
        step(3,  16'h2C98, 1'b1, 1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b0,
             mk(3'd6, 3'd2, 3'd3, 16'hBEEF, 16'h1234, 16'h0018, 3'd1, C_R));
        // OR r7 = r0 | r2 while writing R0 = FFFF: R0 must stay zero
        step(4,  16'h4E10, 1'b1, 1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0,
             mk(3'd7, 3'd0, 3'd2, 16'h0000, 16'hBEEF, 16'h0010, 3'd3, C_R));
        step(5,  16'h3200, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd2, C_R));
        // R1 = 0011, R4 = 4444
        step(6,  16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0011, 1'b0, BUB);
        step(7,  16'h0000, 1'b0, 1'b0, 1'b1, 3'd4, 16'h4444, 1'b0, BUB);
        // LD r4, then ADD r5 = r4 + r1: one stall, WB to R4 during the stall
        step(8,  16'h6842, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd4, 3'd1, 3'd0, 16'h0011, 16'h0000, 16'h0002, 3'd0, C_LD));
        step(9,  16'h1B08, 1'b1, 1'b0, 1'b1, 3'd4, 16'h5555, 1'b1, BUB);
        step(10, 16'h1B08, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd5, 3'd4, 3'd1, 16'h5555, 16'h0011, 16'h0008, 3'd0, C_R));
        // LD r4, then ST using r4 as rs2: stalls
        step(11, 16'h6842, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd4, 3'd1, 3'd0, 16'h0011, 16'h0000, 16'h0002, 3'd0, C_LD));
        step(12, 16'h70A1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, BUB);
        step(13, 16'h70A1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd0, 3'd2, 3'd4, 16'hBEEF, 16'h5555, 16'hFFE1, 3'd0, C_ST));
        // LD r4, then ADDI with 4 in the rs2 field: no stall
        step(14, 16'h6842, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd4, 3'd1, 3'd0, 16'h0011, 16'h0000, 16'h0002, 3'd0, C_LD));
        step(15, 16'h5660, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd3, 3'd1, 3'd0, 16'h0011, 16'h0000, 16'hFFE0, 3'd0, C_ADDI));
        // LD r4, then flush while the hazard is present: flush wins
        step(16, 16'h6842, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd4, 3'd1, 3'd0, 16'h0011, 16'h0000, 16'h0002, 3'd0, C_LD));
        step(17, 16'h1B08, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, BUB);
        // ADDI imm6 = 3F, opcode 12, BEQ
        step(18, 16'h543F, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd2, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'hFFFF, 3'd0, C_ADDI));
        step(19, 16'hCFFF, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, C_NOP));
        step(20, 16'h808D, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd0, 3'd2, 3'd1, 16'hBEEF, 16'h0011, 16'h000D, 3'd1, C_BEQ));
        step(21, 16'h6842, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd4, 3'd1, 3'd0, 16'h0011, 16'h0000, 16'h0002, 3'd0, C_LD));

        // Hazard pending, then asynchronous reset before the next edge
        bus.Instr_IF_ID = 16'h1B08;
        bus.Valid_IF_ID = 1'b1;
        #1;
        check("stall_pre_reset", 22, {65'h0, bus.Stall_IF}, 66'h1);
        reset = 1'b1;
        #1;
        check("stall_in_reset", 22, {65'h0, bus.Stall_IF}, 66'h0);
        check("idex_in_reset", 22, idex_s, BUB);
        @(negedge clk);
        reset = 1'b0;
        // Register file was cleared: ADD r5 = r4 + r1 reads zeros
        step(23, 16'h1B08, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
             mk(3'd5, 3'd4, 3'd1, 16'h0000, 16'h0000, 16'h0008, 3'd0, C_R));
        step(24, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, BUB);

        @(negedge clk);
        @(negedge clk);
        check("drain", 99, 66'(exp_q.size()), 66'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Instruction-decode stage of the 16-bit pipelined processor. It sits between the IF/ID register and the EX stage, and contains the 8x16 register file and the load-use hazard detector. It also owns the ID/EX pipeline register, whose RegRd_ID_EX output feeds the forwarding unit. It accepts one instruction per cycle, stalls fetch on a load-use hazard, and inserts bubbles on stall or flush.

Parameters:
DATA_W, 16, register and operand width
REG_AW, 3, register address width (8 registers)
NUM_REGS, 8, register file depth

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Instr_IF_ID  in  16  instruction from IF/ID register
Valid_IF_ID  in  1  IF/ID holds a real instruction
Flush_EX  in  1  branch taken in EX; kill the instruction in ID
WbEn  in  1  write-back enable
WbAddr  in  3  write-back register
WbData  in  16  write-back data
Stall_IF  out  1  hold PC and IF/ID this cycle (combinational)
RegRd_ID_EX  out  3  destination register in ID/EX
RegRs1_ID_EX  out  3  source 1 address in ID/EX
RegRs2_ID_EX  out  3  source 2 address in ID/EX
Rs1Data_ID_EX  out  16  source 1 operand
Rs2Data_ID_EX  out  16  source 2 operand
Imm_ID_EX  out  16  sign-extended imm6
AluOp_ID_EX  out  3  ALU operation code
AluSrcImm_ID_EX  out  1  ALU B operand = immediate
MemRd_ID_EX  out  1  load
MemWr_ID_EX  out  1  store
RegWr_ID_EX  out  1  writes rd
Branch_ID_EX  out  1  BEQ
Valid_ID_EX  out  1  ID/EX holds a real instruction

Behaviour:
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR (R-type: AluOp 0..3)
  - 5 ADDI (AluOp 0, imm)
  - 6 LD: rd <= mem[rs1+imm]
  - 7 ST: mem[rs1+imm] <= rs2 (rd field ignored; RegWr=0)
  - 8 BEQ: compare rs1, rs2 (AluOp 1, Branch=1)
  - 9..15 decode as NOP.
- Register file: 8x16 flip-flops, written on the rising clock edge when WbEn=1 and WbAddr!=0.
  - R0 always reads 0 and is never written.
  - Reads are combinational with write-through bypass: if WbEn and WbAddr==rs and rs!=0, the read returns WbData in the same cycle.
- Source use:
  - rs1 is used by ADD..LD, ST and BEQ.
  - rs2 is used by R-type, ST and BEQ.
  - Unused sources are reported as address 0 in RegRs1/RegRs2_ID_EX.
- Load-use hazard: Stall_IF = Valid_IF_ID & Valid_ID_EX & MemRd_ID_EX & (RegRd_ID_EX!=0) & (RegRd_ID_EX == a used rs1 or rs2 of Instr_IF_ID) & ~Flush_EX.
- ID/EX update each rising edge, in priority order:
  - reset: all ID/EX outputs 0 (a bubble). Register file contents are also cleared to 0.
  - Flush_EX: load a bubble. Valid, RegWr, MemRd, MemWr and Branch all 0; other fields 0.
  - Stall_IF: load a bubble. IF/ID is held externally, so the same instruction is re-decoded next cycle.
  - Valid_IF_ID=0: load a bubble.
  - otherwise: latch the decoded fields. Latency is 1 cycle, IF/ID to ID/EX.
- A stall lasts exactly 1 cycle. After the bubble, MemRd_ID_EX=0, so the hazard clears.
- Flush and stall in the same cycle: flush wins and Stall_IF is 0.
- Write-back and hazard in the same cycle are independent: WB bypass does not suppress the stall.
- Reset asserted mid-stall: Stall_IF falls immediately because Valid_ID_EX goes to 0 asynchronously.
- Imm: sign-extend imm6 to 16 bits, e.g. 6'h3F -> 16'hFFFF.

Decomposition:
- Shared package: opcode constants, AluOp constants, and widths DATA_W and REG_AW.
- One sub-module: reg_file_8x16, containing the storage, the R0 rule and the write-through bypass.
- Decode, hazard detection and the ID/EX register stay in id_decode_stage.

Test Plan:
1. Reset, then write R3=16'h1234 via WB. Present ADD rd=1, rs1=3, rs2=0 -> next cycle Rs1Data_ID_EX=16'h1234, Rs2Data=0, RegRd_ID_EX=1, RegWr=1, Valid=1.
2. Bypass: WbEn=1, WbAddr=2, WbData=16'hBEEF in the same cycle as decoding SUB rs1=2 -> Rs1Data_ID_EX=16'hBEEF. A write to R0 afterwards still reads 0.
3. Load-use: LD r4 in ID/EX, then ADD r5=r4+r1 in IF/ID -> Stall_IF=1 for exactly 1 cycle and a bubble enters ID/EX (Valid=0). Next cycle the ADD is latched and Stall_IF=0. ST with r4 as rs2 also stalls; ADDI with r4 in the rs2 field does not.
4. Flush_EX=1 while IF/ID holds ADD and a load-use hazard is present -> Stall_IF=0 and ID/EX becomes a bubble.
5. ADDI imm6=6'h3F -> Imm_ID_EX=16'hFFFF, AluSrcImm=1. Opcode 12 -> all control signals 0, Valid_ID_EX=1.
6. Assert reset asynchronously mid-stream -> all ID/EX outputs and Stall_IF go to 0 before the next edge. Register reads return 0.
